// File: rtl/card_dealer_if.sv
// Handshake and hand bus between the card dealer and the game controller/datapath.
interface card_dealer_if #(
  parameter int MAX_HAND = 4
);
  logic                  DEAL;
  logic [2:0]            NUM_CARDS;
  logic                  SEED_LOAD;
  logic [15:0]           SEED;
  logic [6*MAX_HAND-1:0] P1_IN_CARDS;
  logic [6*MAX_HAND-1:0] P2_IN_CARDS;
  logic [2:0]            NUM_OUT;
  logic                  BUSY;
  logic                  DEAL_DONE;

  modport master (
    output DEAL, NUM_CARDS, SEED_LOAD, SEED,
    input  P1_IN_CARDS, P2_IN_CARDS, NUM_OUT, BUSY, DEAL_DONE
  );

  modport slave (
    input  DEAL, NUM_CARDS, SEED_LOAD, SEED,
    output P1_IN_CARDS, P2_IN_CARDS, NUM_OUT, BUSY, DEAL_DONE
  );
endinterface

// File: rtl/card_dealer.sv
// LFSR-driven deck shuffler dealing two duplicate-free hands of up to MAX_HAND cards.
// Optional DEALER_SORT_EN adds an odd-even transposition sort of both hands before DONE.
module card_dealer #(
  parameter int          MAX_HAND  = 4,
  parameter int          DECK_SIZE = 52,
  parameter logic [15:0] LFSR_INIT = 16'hACE1
) (
  input  logic         clka,
  input  logic         RESTART,
  card_dealer_if.slave bus
);

  typedef logic [MAX_HAND-1:0][5:0] hand_t;

  typedef enum logic [2:0] {
    IDLE,
    CLEAR,
    DRAW,
`ifdef DEALER_SORT_EN
    SORT,
`endif
    DONE
  } state_t;

  state_t               state_q, state_d;
  logic [15:0]          lfsr_q, lfsr_d;
  hand_t                p1_q, p1_d;
  hand_t                p2_q, p2_d;
  logic [2:0]           num_q, num_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;
  logic [DECK_SIZE-1:0] used_q, used_d;
  logic [2:0]           k_q, k_d;
  logic                 p2turn_q, p2turn_d;
  logic [5:0]           cand;
  logic                 hit;
`ifdef DEALER_SORT_EN
  logic [$clog2(MAX_HAND)-1:0] sort_q, sort_d;

  // Empty slots (0) must sink to the top, so 0 gets the MSB of the sort key.
  function automatic logic [6:0] key(logic [5:0] c);
    return {c == 6'd0, c};
  endfunction

  function automatic hand_t oe_pass(hand_t h, logic odd);
    hand_t      r;
    logic [5:0] t;
    r = h;
    for (int i = 0; i < MAX_HAND-1; i++) begin
      if (((i % 2) == 1) == odd && key(r[i]) > key(r[i+1])) begin
        t      = r[i];
        r[i]   = r[i+1];
        r[i+1] = t;
      end
    end
    return r;
  endfunction
`endif

  always_ff @(posedge clka) begin
    if (RESTART) begin
      state_q  <= IDLE;
      lfsr_q   <= LFSR_INIT;
      p1_q     <= '0;
      p2_q     <= '0;
      num_q    <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      used_q   <= '0;
      k_q      <= '0;
      p2turn_q <= 1'b0;
`ifdef DEALER_SORT_EN
      sort_q   <= '0;
`endif
    end else begin
      state_q  <= state_d;
      lfsr_q   <= lfsr_d;
      p1_q     <= p1_d;
      p2_q     <= p2_d;
      num_q    <= num_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      used_q   <= used_d;
      k_q      <= k_d;
      p2turn_q <= p2turn_d;
`ifdef DEALER_SORT_EN
      sort_q   <= sort_d;
`endif
    end
  end

  always_comb begin
    state_d  = state_q;
    lfsr_d   = lfsr_q;
    p1_d     = p1_q;
    p2_d     = p2_q;
    num_d    = num_q;
    busy_d   = busy_q;
    done_d   = done_q;
    used_d   = used_q;
    k_d      = k_q;
    p2turn_d = p2turn_q;
    cand     = '0;
    hit      = 1'b0;
`ifdef DEALER_SORT_EN
    sort_d   = sort_q;
`endif

    unique case (state_q)
      IDLE: begin
        // Seed load is applied before DEAL so a same-cycle deal uses the new seed.
        if (bus.SEED_LOAD)
          lfsr_d = (bus.SEED == 16'd0) ? LFSR_INIT : bus.SEED;
        if (bus.DEAL) begin
          num_d   = (bus.NUM_CARDS > 3'(MAX_HAND)) ? 3'(MAX_HAND) : bus.NUM_CARDS;
          p1_d    = '0;
          p2_d    = '0;
          done_d  = 1'b0;
          busy_d  = 1'b1;
          state_d = CLEAR;
        end
      end

      CLEAR: begin
        used_d   = '0;
        k_d      = '0;
        p2turn_d = 1'b0;
`ifdef DEALER_SORT_EN
        sort_d   = '0;
`endif
        state_d  = (num_q == 3'd0) ? DONE : DRAW;
      end

      DRAW: begin
        lfsr_d = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
        cand   = lfsr_d[5:0];
        for (int j = 0; j < DECK_SIZE; j++)
          if (cand == 6'(j+1) && used_q[j]) hit = 1'b1;
        if (cand != 6'd0 && cand <= 6'(DECK_SIZE) && !hit) begin
          for (int j = 0; j < DECK_SIZE; j++)
            if (cand == 6'(j+1)) used_d[j] = 1'b1;
          for (int i = 0; i < MAX_HAND; i++) begin
            if (k_q == 3'(i)) begin
              if (p2turn_q) p2_d[i] = cand;
              else          p1_d[i] = cand;
            end
          end
          p2turn_d = !p2turn_q;
          if (p2turn_q) begin
            k_d = k_q + 3'd1;
            if (k_d == num_q) begin
`ifdef DEALER_SORT_EN
              state_d = SORT;
`else
              state_d = DONE;
`endif
            end
          end
        end
      end

`ifdef DEALER_SORT_EN
      SORT: begin
        // Even pairs on even passes, odd pairs on odd passes; MAX_HAND passes fully sort.
        p1_d   = oe_pass(p1_q, sort_q[0]);
        p2_d   = oe_pass(p2_q, sort_q[0]);
        sort_d = sort_q + 1'b1;
        if (sort_q == ($clog2(MAX_HAND))'(MAX_HAND-1)) state_d = DONE;
      end
`endif

      DONE: state_d = IDLE;

      default: state_d = IDLE;
    endcase

    if (state_d == DONE && state_q != DONE) begin
      busy_d = 1'b0;
      done_d = 1'b1;
    end
  end

  assign bus.P1_IN_CARDS = p1_q;
  assign bus.P2_IN_CARDS = p2_q;
  assign bus.NUM_OUT     = num_q;
  assign bus.BUSY        = busy_q;
  assign bus.DEAL_DONE   = done_q;

endmodule
